// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and lap buttons drive a 4-state FSM
// that produces count ticks, a clear pulse and display-freeze/running flags.
module stopwatch_ctrl #(
  parameter int unsigned DIV       = 1000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clk100_i,
  input  logic       rst_i,
  input  logic       start_stop_i,
  input  logic       lap_i,
  output logic       tick_o,
  output logic       clr_o,
  output logic       freeze_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned DbW  = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStop = 2'b10,
    StLap  = 2'b11
  } state_e;

  logic [1:0] w_raw;
  logic [1:0] w_evt;

  assign w_raw = {lap_i, start_stop_i};

  // Index 0 is start/stop, index 1 is lap.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic           r_meta;
    logic           r_sync;
    logic           r_db;
    logic           r_db_prev;
    logic [DbW-1:0] r_cnt;

    always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_db      <= 1'b0;
        r_db_prev <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_meta    <= w_raw[g];
        r_sync    <= r_meta;
        r_db_prev <= r_db;
        if (r_sync == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == DbW'(DB_CYCLES - 1)) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DbW'(1);
        end
      end
    end

    assign w_evt[g] = r_db & ~r_db_prev;
  end

  state_e          r_state;
  state_e          w_state_next;
  logic [DivW-1:0] r_div;
  logic            r_clr;
  logic            w_start;
  logic            w_lap;
  logic            w_active;
  logic            w_div_end;
  logic            w_to_idle;

  assign w_start   = w_evt[0];
  assign w_lap     = w_evt[1];
  assign w_active  = (r_state == StRun) || (r_state == StLap);
  assign w_div_end = (r_div == DivW'(DIV - 1));
  assign w_to_idle = (r_state == StStop) && (w_state_next == StIdle);

  // Start has priority over lap when both events land in the same cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_start) w_state_next = StRun;
      StRun: begin
        if (w_start)    w_state_next = StStop;
        else if (w_lap) w_state_next = StLap;
      end
      StLap: begin
        if (w_start)    w_state_next = StStop;
        else if (w_lap) w_state_next = StRun;
      end
      StStop: begin
        if (w_start)    w_state_next = StRun;
        else if (w_lap) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_clr   <= w_to_idle;
      // Divider holds in STOP so a resume keeps the partial period.
      if (w_to_idle) begin
        r_div <= '0;
      end else if (w_active) begin
        r_div <= w_div_end ? '0 : r_div + DivW'(1);
      end
    end
  end

  assign tick_o    = w_active && w_div_end;
  assign clr_o     = r_clr;
  assign freeze_o  = (r_state == StLap);
  assign running_o = w_active;
  assign state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=5, DB_CYCLES=4: vector table plus
// hand sequences for reset-in-LAP and button-held-through-reset latency.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       lap;
  logic       tick;
  logic       clr;
  logic       frz;
  logic       run;
  logic [1:0] st;

  int n_checks = 0;
  int n_err    = 0;

  stopwatch_ctrl #(
    .DIV      (5),
    .DB_CYCLES(4)
  ) dut (
    .clk100_i    (clk),
    .rst_i       (rst),
    .start_stop_i(ss),
    .lap_i       (lap),
    .tick_o      (tick),
    .clr_o       (clr),
    .freeze_o    (frz),
    .running_o   (run),
    .state_o     (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       lap;
    int         n;
    logic [1:0] st;
    logic       run;
    logic       frz;
    int         ticks;
    int         clrs;
    int         laps;
  } vec_t;

  vec_t vecs [21];

  int c_ticks;
  int c_clrs;
  int c_laps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge.
  task automatic run_cycles(input int n);
    c_ticks = 0;
    c_clrs  = 0;
    c_laps  = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      c_ticks += int'(tick);
      c_clrs  += int'(clr);
      c_laps  += int'(frz);
    end
  endtask

  task automatic press(input logic p_ss, input logic p_lap);
    ss  = p_ss;
    lap = p_lap;
    run_cycles(10);
    ss  = 1'b0;
    lap = 1'b0;
    run_cycles(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ss    lap   n   st     run   frz   tk cl lp
    vecs[0]  = '{1'b1, 1'b0, 2,  2'b00, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 8,  2'b00, 1'b0, 1'b0, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 20, 2'b01, 1'b1, 1'b0, 2, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 8,  2'b01, 1'b1, 1'b0, 2, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 10, 2'b11, 1'b1, 1'b1, 2, 0, 4};
    vecs[5]  = '{1'b0, 1'b0, 8,  2'b11, 1'b1, 1'b1, 2, 0, 8};
    vecs[6]  = '{1'b0, 1'b1, 10, 2'b01, 1'b1, 1'b0, 2, 0, 6};
    vecs[7]  = '{1'b0, 1'b0, 8,  2'b01, 1'b1, 1'b0, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 3,  2'b01, 1'b1, 1'b0, 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 10, 2'b10, 1'b0, 1'b0, 1, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 8,  2'b10, 1'b0, 1'b0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 10, 2'b01, 1'b1, 1'b0, 1, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 8,  2'b01, 1'b1, 1'b0, 1, 0, 0};
    vecs[13] = '{1'b1, 1'b0, 10, 2'b10, 1'b0, 1'b0, 2, 0, 0};
    vecs[14] = '{1'b0, 1'b0, 8,  2'b10, 1'b0, 1'b0, 0, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 10, 2'b00, 1'b0, 1'b0, 0, 1, 0};
    vecs[16] = '{1'b0, 1'b0, 8,  2'b00, 1'b0, 1'b0, 0, 0, 0};
    vecs[17] = '{1'b1, 1'b1, 10, 2'b01, 1'b1, 1'b0, 0, 0, 0};
    vecs[18] = '{1'b0, 1'b0, 8,  2'b01, 1'b1, 1'b0, 2, 0, 0};
    vecs[19] = '{1'b1, 1'b1, 10, 2'b10, 1'b0, 1'b0, 1, 0, 0};
    vecs[20] = '{1'b0, 1'b0, 8,  2'b10, 1'b0, 1'b0, 0, 0, 0};

    rst = 1'b1;
    ss  = 1'b0;
    lap = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", 32'(st), 32'd0);
    check("reset outs", {28'd0, tick, clr, frz, run}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      ss  = vecs[i].ss;
      lap = vecs[i].lap;
      run_cycles(vecs[i].n);
      check($sformatf("v%0d state", i), 32'(st), 32'(vecs[i].st));
      check($sformatf("v%0d running", i), 32'(run), 32'(vecs[i].run));
      check($sformatf("v%0d freeze", i), 32'(frz), 32'(vecs[i].frz));
      check($sformatf("v%0d ticks", i), 32'(c_ticks), 32'(vecs[i].ticks));
      check($sformatf("v%0d clrs", i), 32'(c_clrs), 32'(vecs[i].clrs));
      check($sformatf("v%0d lap cycles", i), 32'(c_laps), 32'(vecs[i].laps));
    end

    // STOP -> RUN -> LAP, then reset between edges.
    press(1'b1, 1'b0);
    check("pre-rst run", 32'(st), 32'd1);
    press(1'b0, 1'b1);
    check("pre-rst lap", 32'(st), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async rst state", 32'(st), 32'd0);
    check("async rst outs", {28'd0, tick, clr, frz, run}, 32'd0);

    // Start held through reset release: event needs sync + DB_CYCLES cycles.
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_clrs = 0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      @(negedge clk);
      c_clrs += int'(clr);
      check($sformatf("held s%0d state", i), 32'(st), (i >= 7) ? 32'd1 : 32'd0);
      check($sformatf("held s%0d tick", i), 32'(tick),
            (i >= 7 && ((i - 7) % 5) == 4) ? 32'd1 : 32'd0);
    end
    check("no clr after rst", 32'(c_clrs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
